// File: rtl/core_pkg.sv
// Shared constants for the core's register-file slice.
//   XLEN_DEF / NREGS_DEF / AW_DEF : default datapath width, register count, address width
//   NREAD_DEF / NWRITE_DEF        : default read/write port counts
//   REG_SP_ZR                     : architectural index that aliases SP or XZR
//   RD_* / WR_*                   : symbolic port numbers used by decode and writeback
package core_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int NREGS_DEF  = 32;
  localparam int AW_DEF     = $clog2(NREGS_DEF);
  localparam int NREAD_DEF  = 3;
  localparam int NWRITE_DEF = 2;

  localparam logic [4:0] REG_SP_ZR = 5'd31;

  // Read ports: first source, second source, store data / accumulate operand
  localparam int RD_RN = 0;
  localparam int RD_RM = 1;
  localparam int RD_RT = 2;

  // Write ports: higher number wins a same-address collision
  localparam int WR_ALU = 0;
  localparam int WR_LD  = 1;

endpackage

// File: rtl/reg_file_rd_port.sv
// One read port of the multi-port register file.
// Ports:
//   addr, use_sp              : register index and SP/XZR qualifier for index NREGS-1
//   stored_data, stored_busy  : pre-edge register contents and busy bit (0 when out of range)
//   wr_eff, wr_addr, wr_val   : this cycle's effective writes (final write values), all ports
//   sb_eff, sb_addr           : this cycle's effective scoreboard set
//   data, busy                : combinational read result and busy flag
module reg_file_rd_port
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int NWRITE = NWRITE_DEF,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]          addr,
  input  logic                   use_sp,
  input  logic [XLEN-1:0]        stored_data,
  input  logic                   stored_busy,
  input  logic [NWRITE-1:0]      wr_eff,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_val,
  input  logic                   sb_eff,
  input  logic [AW-1:0]          sb_addr,
  output logic [XLEN-1:0]        data,
  output logic                   busy
);

  localparam logic [AW-1:0] SP_IDX = AW'(NREGS - 1);

  logic is_zr;
  logic wr_hit;
  logic sb_hit;

  assign is_zr  = (addr == SP_IDX) && !use_sp;
  assign sb_hit = sb_eff && (sb_addr == addr);

  always_comb begin
    data   = stored_data;
    wr_hit = 1'b0;
    // Ascending scan so the highest-numbered matching port supplies the value,
    // matching the collision priority of the storage update.
    if (BYPASS != 0) begin
      for (int j = 0; j < NWRITE; j++) begin
        if (wr_eff[j] && (wr_addr[j*AW +: AW] == addr)) begin
          data   = wr_val[j*XLEN +: XLEN];
          wr_hit = 1'b1;
        end
      end
    end
    // A retiring producer hides the busy bit unless a new producer is issued
    // to the same register in this cycle.
    busy = stored_busy && !(wr_hit && !sb_hit);
    if (is_zr) begin
      data = '0;
      busy = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port AArch64 general register file with busy scoreboard.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   rd_addr, rd_use_sp    : NREAD packed read addresses and SP/XZR qualifiers
//   rd_data, rd_busy      : combinational read data and busy flags
//   wr_en, wr_addr,
//   wr_data, wr_use_sp,
//   wr_w32                : NWRITE write ports; W-form writes zero-extend the low 32 bits
//   sb_set, sb_addr,
//   sb_use_sp             : mark a destination register busy at issue
module reg_file_mp
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int AW     = $clog2(NREGS),
  parameter int NREAD  = NREAD_DEF,
  parameter int NWRITE = NWRITE_DEF,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  input  logic [NREAD-1:0]       rd_use_sp,
  output logic [NREAD*XLEN-1:0]  rd_data,
  output logic [NREAD-1:0]       rd_busy,
  input  logic [NWRITE-1:0]      wr_en,
  input  logic [NWRITE*AW-1:0]   wr_addr,
  input  logic [NWRITE*XLEN-1:0] wr_data,
  input  logic [NWRITE-1:0]      wr_use_sp,
  input  logic [NWRITE-1:0]      wr_w32,
  input  logic                   sb_set,
  input  logic [AW-1:0]          sb_addr,
  input  logic                   sb_use_sp
);

  localparam logic [AW-1:0] SP_IDX    = AW'(NREGS - 1);
  localparam logic [AW:0]   NREGS_LIM = (AW+1)'(NREGS);

  logic [XLEN-1:0]        regs_reg  [NREGS];
  logic [XLEN-1:0]        regs_next [NREGS];
  logic [NREGS-1:0]       busy_reg;
  logic [NREGS-1:0]       busy_next;
  logic [NWRITE-1:0]      wr_eff;
  logic [NWRITE*XLEN-1:0] wr_val;
  logic                   sb_eff;

  // Per write port: qualify the enable (XZR target, out-of-range index and
  // the reset cycle all suppress the write) and form the stored value.
  genvar gi;
  generate
    for (gi = 0; gi < NWRITE; gi++) begin : g_wr
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      assign a = wr_addr[gi*AW +: AW];
      assign d = wr_data[gi*XLEN +: XLEN];
      assign wr_eff[gi] = !reset && wr_en[gi] && ({1'b0, a} < NREGS_LIM) &&
                          !((a == SP_IDX) && !wr_use_sp[gi]);
      if (XLEN > 32) begin : g_w32
        assign wr_val[gi*XLEN +: XLEN] = wr_w32[gi] ? {{(XLEN-32){1'b0}}, d[31:0]} : d;
      end else begin : g_x32
        assign wr_val[gi*XLEN +: XLEN] = d;
      end
    end
  endgenerate

  assign sb_eff = !reset && sb_set && ({1'b0, sb_addr} < NREGS_LIM) &&
                  !((sb_addr == SP_IDX) && !sb_use_sp);

  always_comb begin
    regs_next = regs_reg;
    busy_next = busy_reg;
    // Later ports overwrite earlier ones: the load port beats the ALU port.
    for (int j = 0; j < NWRITE; j++) begin
      if (wr_eff[j]) begin
        regs_next[wr_addr[j*AW +: AW]] = wr_val[j*XLEN +: XLEN];
        busy_next[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    // Applied after the clears so a newly issued producer keeps the bit set.
    if (sb_eff) begin
      busy_next[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        regs_reg[r] <= regs_next[r];
      end
      busy_reg <= busy_next;
    end
  end

  generate
    for (gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0]   a;
      logic            in_rng;
      logic [XLEN-1:0] stored_data;
      logic            stored_busy;
      assign a           = rd_addr[gi*AW +: AW];
      assign in_rng      = ({1'b0, a} < NREGS_LIM);
      assign stored_data = in_rng ? regs_reg[a] : '0;
      assign stored_busy = in_rng ? busy_reg[a] : 1'b0;

      reg_file_rd_port #(
        .XLEN   (XLEN),
        .NREGS  (NREGS),
        .AW     (AW),
        .NWRITE (NWRITE),
        .BYPASS (BYPASS)
      ) u_rd_port (
        .addr        (a),
        .use_sp      (rd_use_sp[gi]),
        .stored_data (stored_data),
        .stored_busy (stored_busy),
        .wr_eff      (wr_eff),
        .wr_addr     (wr_addr),
        .wr_val      (wr_val),
        .sb_eff      (sb_eff),
        .sb_addr     (sb_addr),
        .data        (rd_data[gi*XLEN +: XLEN]),
        .busy        (rd_busy[gi])
      );
    end
  endgenerate

endmodule
